// File: rtl/sonar_rx_quadro.sv
// Sonar link receiver: UART deserialiser (7 data bits, odd parity, 1 stop bit) followed by a
// parser for measurement frames "AAA,DDDD#". Presents the last good angle/distance in BCD,
// with a one-cycle pronto pulse per good frame and a one-cycle erro pulse per discarded one.
module sonar_rx_quadro #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        entrada_serial_i,
    output logic [11:0] angulo_o,
    output logic [15:0] distancia_o,
    output logic        pronto_o,
    output logic        erro_o,
    output logic [3:0]  db_estado_o
);

    localparam int unsigned Div  = CLK_FREQ / BAUD;
    localparam int unsigned CntW = $clog2(Div);
    localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);

    localparam logic [6:0] AsciiHash  = 7'h23;
    localparam logic [6:0] AsciiComma = 7'h2C;

    typedef enum logic [2:0] {
        StInicial   = 3'd0,
        StMeioStart = 3'd1,
        StDados     = 3'd2,
        StParidade  = 3'd3,
        StStop      = 3'd4,
        StEntrega   = 3'd5
    } rx_state_e;

    // Line synchroniser plus one extra flop for falling-edge detection; idle level is high.
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= entrada_serial_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      data_q, data_d;
    logic            par_q, par_d;
    logic            bad_q, bad_d;

    // Receiver state and bit-timing registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StInicial;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            bad_q     <= bad_d;
        end
    end

    // Receiver next state: half-bit wait to centre on the start bit, then one sample per bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        bad_d     = bad_q;
        case (state_q)
            StInicial: begin
                if (prev_q && !sync2_q) begin
                    state_d = StMeioStart;
                    cnt_d   = '0;
                end
            end
            StMeioStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    // Line back high at mid-start means a glitch, not a start bit.
                    state_d   = sync2_q ? StInicial : StDados;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDados: begin
                if (cnt_q == CntFull) begin
                    cnt_d  = '0;
                    data_d = {sync2_q, data_q[6:1]};
                    if (bit_cnt_q == 3'd6) begin
                        state_d = StParidade;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParidade: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    par_d   = sync2_q;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    // Odd parity: data plus parity bit must hold an odd number of ones.
                    bad_d   = ~(^{data_q, par_q}) | ~sync2_q;
                    state_d = StEntrega;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEntrega: state_d = StInicial;
            default:   state_d = StInicial;
        endcase
    end

    logic byte_vld;
    logic is_digit, is_hash, is_comma;

    assign byte_vld = (state_q == StEntrega);
    assign is_digit = (data_q[6:4] == 3'b011) && (data_q[3:0] <= 4'd9);
    assign is_hash  = (data_q == AsciiHash);
    assign is_comma = (data_q == AsciiComma);

    logic [3:0]  idx_q, idx_d;
    logic        descarte_q, descarte_d;
    logic [11:0] ang_buf_q, ang_buf_d;
    logic [15:0] dist_buf_q, dist_buf_d;
    logic [11:0] angulo_q, angulo_d;
    logic [15:0] distancia_q, distancia_d;
    logic        pronto_q, pronto_d;
    logic        erro_q, erro_d;

    // Parser registers; the frame buffer is kept apart so partial frames never reach the outputs.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idx_q       <= '0;
            descarte_q  <= 1'b0;
            ang_buf_q   <= '0;
            dist_buf_q  <= '0;
            angulo_q    <= '0;
            distancia_q <= '0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            descarte_q  <= descarte_d;
            ang_buf_q   <= ang_buf_d;
            dist_buf_q  <= dist_buf_d;
            angulo_q    <= angulo_d;
            distancia_q <= distancia_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    // Parser next state: one decision per delivered byte.
    always_comb begin
        idx_d       = idx_q;
        descarte_d  = descarte_q;
        ang_buf_d   = ang_buf_q;
        dist_buf_d  = dist_buf_q;
        angulo_d    = angulo_q;
        distancia_d = distancia_q;
        pronto_d    = 1'b0;
        erro_d      = 1'b0;
        if (byte_vld) begin
            if (descarte_q) begin
                // Only a clean '#' ends the discard; it raises nothing itself.
                if (!bad_q && is_hash) begin
                    descarte_d = 1'b0;
                    idx_d      = '0;
                end
            end else if (bad_q) begin
                erro_d     = 1'b1;
                descarte_d = 1'b1;
            end else if (is_hash) begin
                idx_d = '0;
                if (idx_q == 4'd8) begin
                    angulo_d    = ang_buf_q;
                    distancia_d = dist_buf_q;
                    pronto_d    = 1'b1;
                end else begin
                    // Early '#' resynchronises directly.
                    erro_d = 1'b1;
                end
            end else if ((idx_q == 4'd3) ? is_comma : (idx_q != 4'd8 && is_digit)) begin
                case (idx_q)
                    4'd0:    ang_buf_d[11:8]   = data_q[3:0];
                    4'd1:    ang_buf_d[7:4]    = data_q[3:0];
                    4'd2:    ang_buf_d[3:0]    = data_q[3:0];
                    4'd4:    dist_buf_d[15:12] = data_q[3:0];
                    4'd5:    dist_buf_d[11:8]  = data_q[3:0];
                    4'd6:    dist_buf_d[7:4]   = data_q[3:0];
                    4'd7:    dist_buf_d[3:0]   = data_q[3:0];
                    default: ;
                endcase
                idx_d = idx_q + 4'd1;
            end else begin
                erro_d     = 1'b1;
                descarte_d = 1'b1;
            end
        end
    end

    assign angulo_o    = angulo_q;
    assign distancia_o = distancia_q;
    assign pronto_o    = pronto_q;
    assign erro_o      = erro_q;
    assign db_estado_o = {1'b0, state_q};

endmodule

// File: tb/tb_sonar_rx_quadro.sv
// Bench for sonar_rx_quadro: directed frames plus randomised frames with injected faults,
// checked every cycle against a frame-level model of expected pronto/erro events.
module tb_sonar_rx_quadro;

    localparam int unsigned Div = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        line = 1'b1;
    logic [11:0] angulo;
    logic [15:0] distancia;
    logic        pronto, erro;
    logic [3:0]  db_estado;

    sonar_rx_quadro #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .clock_i         (clock),
        .reset_ni        (reset_n),
        .entrada_serial_i(line),
        .angulo_o        (angulo),
        .distancia_o     (distancia),
        .pronto_o        (pronto),
        .erro_o          (erro),
        .db_estado_o     (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit          is_pronto;
        logic [11:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t         exp_q[$];
    logic [6:0]  m_buf[$];
    bit          m_discard = 1'b0;
    logic [11:0] shown_a = '0;
    logic [15:0] shown_d = '0;
    int          checks = 0;
    int          errors = 0;
    int          n_pronto = 0;
    int          n_erro = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Frame-level reference: what a byte should cause, given the good characters seen so far.
    task automatic model_byte(input logic [6:0] c, input bit bad);
        ev_t e;
        bit  dig;
        dig = (c >= 7'h30) && (c <= 7'h39);
        e.is_pronto = 1'b0;
        e.a = '0;
        e.d = '0;
        if (m_discard) begin
            if (!bad && c == 7'h23) begin
                m_discard = 1'b0;
                m_buf.delete();
            end
        end else if (bad) begin
            exp_q.push_back(e);
            m_discard = 1'b1;
        end else if (c == 7'h23) begin
            if (m_buf.size() == 8) begin
                e.is_pronto = 1'b1;
                e.a = {m_buf[0][3:0], m_buf[1][3:0], m_buf[2][3:0]};
                e.d = {m_buf[4][3:0], m_buf[5][3:0], m_buf[6][3:0], m_buf[7][3:0]};
            end
            exp_q.push_back(e);
            m_buf.delete();
        end else if ((m_buf.size() == 3) ? (c == 7'h2C) : (m_buf.size() < 8 && dig)) begin
            m_buf.push_back(c);
        end else begin
            exp_q.push_back(e);
            m_discard = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_buf.delete();
        m_discard = 1'b0;
        shown_a = '0;
        shown_d = '0;
    endtask

    // Compare process: sampled 2 time units after each rising edge.
    always @(posedge clock) begin
        ev_t ev;
        #2;
        if (!reset_n) begin
            chk("reset_angulo", 32'(angulo), 0);
            chk("reset_distancia", 32'(distancia), 0);
            chk("reset_pulses", 32'({pronto, erro}), 0);
            chk("reset_estado", 32'(db_estado), 0);
        end else begin
            chk("pronto_erro_exclusive", 32'(pronto & erro), 0);
            if (pronto || erro) begin
                if (pronto) n_pronto++;
                if (erro) n_erro++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'({pronto, erro}), 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_kind_pronto", 32'(pronto), 32'(ev.is_pronto));
                    if (ev.is_pronto) begin
                        shown_a = ev.a;
                        shown_d = ev.d;
                    end
                end
            end
            chk("angulo", 32'(angulo), 32'(shown_a));
            chk("distancia", 32'(distancia), 32'(shown_d));
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clock);
        line = b;
        repeat (Div - 1) @(negedge clock);
    endtask

    task automatic send_byte(input logic [6:0] c, input bit flip_par, input bit bad_stop,
                             input int gap);
        logic par;
        model_byte(c, flip_par || bad_stop);
        par = ~(^c) ^ flip_par;
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(c[i]);
        drive_bit(par);
        drive_bit(~bad_stop);
        line = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_frame(input string s, input int gap);
        logic [6:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i][6:0];
            send_byte(c, 1'b0, 1'b0, (i == s.len() - 1) ? gap : 0);
        end
    endtask

    task automatic settle();
        line = 1'b1;
        repeat (3 * Div) @(negedge clock);
        chk("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int         p0, e0;
        bit         seen;
        string      s;
        logic [6:0] c;
        logic [6:0] fr[$];
        int         pos, kind, gap;

        model_reset();
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("idle_estado", 32'(db_estado), 0);

        // 1: single good frame
        p0 = n_pronto; e0 = n_erro;
        send_frame("090,0123#", 0);
        settle();
        chk("t1_pronto_count", n_pronto - p0, 1);
        chk("t1_erro_count", n_erro - e0, 0);
        chk("t1_angulo", 32'(angulo), 32'h090);
        chk("t1_distancia", 32'(distancia), 32'h0123);

        // 2: back-to-back frames, no idle between bytes
        p0 = n_pronto; e0 = n_erro;
        send_frame("000,0005#180,9999#", 0);
        settle();
        chk("t2_pronto_count", n_pronto - p0, 2);
        chk("t2_erro_count", n_erro - e0, 0);
        chk("t2_angulo", 32'(angulo), 32'h180);
        chk("t2_distancia", 32'(distancia), 32'h9999);

        // 3: parity error on 2nd byte, then a good frame
        p0 = n_pronto; e0 = n_erro;
        s = "090,0123#";
        for (int i = 0; i < s.len(); i++) begin
            c = s[i][6:0];
            send_byte(c, i == 1, 1'b0, 0);
        end
        settle();
        chk("t3_first_erro", n_erro - e0, 1);
        chk("t3_first_no_pronto", n_pronto - p0, 0);
        chk("t3_angulo_held", 32'(angulo), 32'h180);
        send_frame("045,0020#", 0);
        settle();
        chk("t3_pronto_count", n_pronto - p0, 1);
        chk("t3_angulo", 32'(angulo), 32'h045);
        chk("t3_distancia", 32'(distancia), 32'h0020);

        // 4: short frame, then a good one
        p0 = n_pronto; e0 = n_erro;
        send_frame("12,0034#", 0);
        settle();
        chk("t4_short_erro", n_erro - e0, 1);
        chk("t4_short_no_pronto", n_pronto - p0, 0);
        send_frame("120,0034#", 0);
        settle();
        chk("t4_pronto_count", n_pronto - p0, 1);
        chk("t4_angulo", 32'(angulo), 32'h120);
        chk("t4_distancia", 32'(distancia), 32'h0034);

        // 5: short low glitch on idle line
        p0 = n_pronto; e0 = n_erro;
        seen = 1'b0;
        @(negedge clock);
        line = 1'b0;
        repeat (Div / 4) @(negedge clock);
        line = 1'b1;
        for (int i = 0; i < 2 * Div; i++) begin
            @(negedge clock);
            if (db_estado == 4'd1) seen = 1'b1;
        end
        chk("t5_start_seen", 32'(seen), 1);
        settle();
        chk("t5_estado_idle", 32'(db_estado), 0);
        chk("t5_no_events", (n_pronto - p0) + (n_erro - e0), 0);

        // 6: reset during 5th byte, then resend
        s = "030,0500#";
        for (int i = 0; i < 4; i++) begin
            c = s[i][6:0];
            send_byte(c, 1'b0, 1'b0, 0);
        end
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        line = 1'b1;
        model_reset();
        repeat (4) @(negedge clock);
        chk("t6_reset_angulo", 32'(angulo), 0);
        chk("t6_reset_distancia", 32'(distancia), 0);
        reset_n = 1'b1;
        settle();
        p0 = n_pronto;
        send_frame(s, 0);
        settle();
        chk("t6_pronto_count", n_pronto - p0, 1);
        chk("t6_angulo", 32'(angulo), 32'h030);
        chk("t6_distancia", 32'(distancia), 32'h0500);

        // Randomised frames with occasional faults
        for (int f = 0; f < 25; f++) begin
            fr.delete();
            for (int i = 0; i < 9; i++) begin
                if (i == 3) fr.push_back(7'h2C);
                else if (i == 8) fr.push_back(7'h23);
                else fr.push_back(7'(7'h30 + $urandom_range(0, 9)));
            end
            kind = $urandom_range(0, 9);
            pos = $urandom_range(0, 8);
            if (kind == 0) fr[pos] = 7'($urandom_range(0, 127));
            if (kind == 3) fr.delete(pos);
            for (int i = 0; i < fr.size(); i++) begin
                gap = (i == fr.size() - 1) ? $urandom_range(0, 30) : 0;
                if (kind == 2 && i == pos) gap = Div + $urandom_range(0, 8);
                send_byte(fr[i], kind == 1 && i == pos, kind == 2 && i == pos, gap);
            end
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
